// File: rtl/bitonic_loader_pkg.sv
// Shared sorter constants: default batch geometry and the pad record
// that sinks to the tail of an ascending bitonic sort.
package bitonic_loader_pkg;
    localparam int P_LOG_DEF = 7;
    localparam int DATW_DEF  = 64;
    localparam int KEYW_DEF  = 32;
    localparam int PAD_MAXW  = 1024;
    // Slice the low DATW bits for the pad record of any supported width.
    localparam logic [PAD_MAXW-1:0] PAD_WORD = '1;
endpackage

// File: rtl/bitonic_loader_if.sv
// Record stream in, assembled batch out toward the bitonic sorter DIN/DINEN.
interface bitonic_loader_if
    import bitonic_loader_pkg::*;
#(
    parameter int P_LOG = P_LOG_DEF,
    parameter int DATW  = DATW_DEF
);
    logic [DATW-1:0]            IDATA;
    logic                       IVALID;
    logic                       IFLUSH;
    logic [(DATW<<P_LOG)-1:0]   DOT;
    logic                       DOTEN;
    logic [P_LOG:0]             DOTPAD;
    logic [31:0]                BATCHCNT;

    modport master (output IDATA, IVALID, IFLUSH,
                    input  DOT, DOTEN, DOTPAD, BATCHCNT);
    modport slave  (input  IDATA, IVALID, IFLUSH,
                    output DOT, DOTEN, DOTPAD, BATCHCNT);
endinterface

// File: rtl/bitonic_loader.sv
// Packs a record stream into N-record batches for the bitonic sorter,
// padding short batches with all-ones records on flush.
module bitonic_loader
    import bitonic_loader_pkg::*;
#(
    parameter int P_LOG = P_LOG_DEF,
    parameter int DATW  = DATW_DEF,
    parameter int KEYW  = KEYW_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    bitonic_loader_if.slave bus
);
    localparam int N = 1 << P_LOG;
    typedef logic [N-1:0][DATW-1:0] batch_t;

    if (KEYW < 1 || KEYW > DATW || DATW > PAD_MAXW) begin : g_param_chk
        $error("bitonic_loader: KEYW must lie in 1..DATW and DATW within PAD_MAXW");
    end

    logic [P_LOG-1:0] cnt;
    logic [P_LOG:0]   cnt_eff;
    logic [N-1:0]     slot_we;
    logic             full;
    logic             emit;
    batch_t           stage;
    batch_t           next_batch;

    // The record arriving this cycle is folded in before any flush is judged,
    // so a completing record never leaves an empty batch behind it.
    always_comb begin
        full       = bus.IVALID && (cnt == P_LOG'(N-1));
        cnt_eff    = {1'b0, cnt} + (P_LOG+1)'(bus.IVALID);
        emit       = full || (bus.IFLUSH && (cnt_eff != '0));
        slot_we    = '0;
        next_batch = '0;
        for (int i = 0; i < N; i++) begin
            slot_we[i] = bus.IVALID && (cnt == P_LOG'(i));
            if (slot_we[i])
                next_batch[i] = bus.IDATA;
            else if ((P_LOG+1)'(i) < cnt_eff)
                next_batch[i] = stage[i];
            else
                next_batch[i] = PAD_WORD[DATW-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (slot_we[i]) stage[i] <= bus.IDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt          <= '0;
            bus.DOT      <= '0;
            bus.DOTEN    <= 1'b0;
            bus.DOTPAD   <= '0;
            bus.BATCHCNT <= '0;
        end else begin
            bus.DOTEN <= emit;
            if (emit) begin
                cnt          <= '0;
                bus.DOT      <= next_batch;
                bus.DOTPAD   <= full ? '0 : (P_LOG+1)'(N) - cnt_eff;
                bus.BATCHCNT <= bus.BATCHCNT + 32'd1;
            end else if (bus.IVALID) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bitonic_loader.sv
// Directed checks of batch assembly, flush padding and async reset.
module tb_bitonic_loader;
    localparam int P_LOG = 2;
    localparam int DATW  = 16;
    localparam int KEYW  = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   pulses;

    always #5 CLK = ~CLK;

    bitonic_loader_if #(.P_LOG(P_LOG), .DATW(DATW)) bus ();

    bitonic_loader #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, return 1 time unit after the next rising edge.
    task automatic step(input logic v, input logic f, input logic [15:0] d);
        @(negedge CLK);
        bus.IVALID = v;
        bus.IFLUSH = f;
        bus.IDATA  = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.IVALID = 1'b0;
        bus.IFLUSH = 1'b0;
        bus.IDATA  = '0;

        #12;
        chk("rst_doten",    64'(bus.DOTEN),    64'd0);
        chk("rst_dot",      bus.DOT,           64'd0);
        chk("rst_dotpad",   64'(bus.DOTPAD),   64'd0);
        chk("rst_batchcnt", 64'(bus.BATCHCNT), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Four descending records form one full batch.
        step(1, 0, 16'h0004);
        step(1, 0, 16'h0003);
        step(1, 0, 16'h0002);
        chk("full_no_early_en", 64'(bus.DOTEN), 64'd0);
        step(1, 0, 16'h0001);
        chk("full_doten",    64'(bus.DOTEN),    64'd1);
        chk("full_dot",      bus.DOT,           64'h0001_0002_0003_0004);
        chk("full_dotpad",   64'(bus.DOTPAD),   64'd0);
        chk("full_batchcnt", 64'(bus.BATCHCNT), 64'd1);
        step(0, 0, 16'h0000);
        chk("full_en_drops", 64'(bus.DOTEN),    64'd0);
        chk("full_dot_hold", bus.DOT,           64'h0001_0002_0003_0004);

        // Eight back-to-back records: strobes on the 4th and 8th only.
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 16'(16'h0A00 + k));
            if (bus.DOTEN) pulses++;
            if (k == 4) chk("b2b_first_en", 64'(bus.DOTEN), 64'd1);
            if (k == 7) chk("b2b_gap_en",   64'(bus.DOTEN), 64'd0);
        end
        chk("b2b_second_en", 64'(bus.DOTEN),    64'd1);
        chk("b2b_pulses",    64'(pulses),       64'd2);
        chk("b2b_dot",       bus.DOT,           64'h0A08_0A07_0A06_0A05);
        chk("b2b_batchcnt",  64'(bus.BATCHCNT), 64'd3);
        step(0, 0, 16'h0000);

        // Two records then a bare flush: two pad slots on top.
        step(1, 0, 16'h0011);
        step(1, 0, 16'h0022);
        step(0, 1, 16'h0000);
        chk("pad_doten",    64'(bus.DOTEN),    64'd1);
        chk("pad_dot",      bus.DOT,           64'hFFFF_FFFF_0022_0011);
        chk("pad_dotpad",   64'(bus.DOTPAD),   64'd2);
        chk("pad_batchcnt", 64'(bus.BATCHCNT), 64'd4);
        step(0, 0, 16'h0000);
        chk("pad_dotpad_hold", 64'(bus.DOTPAD), 64'd2);

        // Flush riding on the completing record yields one unpadded batch.
        step(1, 0, 16'h0101);
        step(1, 0, 16'h0202);
        step(1, 0, 16'h0303);
        step(1, 1, 16'h0404);
        chk("cofl_doten",  64'(bus.DOTEN),  64'd1);
        chk("cofl_dot",    bus.DOT,         64'h0404_0303_0202_0101);
        chk("cofl_dotpad", 64'(bus.DOTPAD), 64'd0);
        step(0, 0, 16'h0000);
        chk("cofl_no_extra", 64'(bus.DOTEN), 64'd0);
        step(0, 1, 16'h0000);
        chk("empty_flush_en",  64'(bus.DOTEN),    64'd0);
        chk("empty_flush_cnt", 64'(bus.BATCHCNT), 64'd5);

        // Flush with the very first record of a batch.
        step(1, 1, 16'h0077);
        chk("one_rec_dot",      bus.DOT,           64'hFFFF_FFFF_FFFF_0077);
        chk("one_rec_dotpad",   64'(bus.DOTPAD),   64'd3);
        chk("one_rec_batchcnt", 64'(bus.BATCHCNT), 64'd6);
        step(0, 0, 16'h0000);

        // Async reset mid-cycle discards a partial batch.
        step(1, 0, 16'hDEAD);
        step(1, 0, 16'hBEEF);
        #1;
        RST = 1'b1;
        bus.IVALID = 1'b0;
        #1;
        chk("arst_batchcnt", 64'(bus.BATCHCNT), 64'd0);
        chk("arst_dot",      bus.DOT,           64'd0);
        #1;
        RST = 1'b0;
        step(1, 0, 16'h0C01);
        step(1, 0, 16'h0C02);
        step(1, 0, 16'h0C03);
        chk("arst_no_stale_en", 64'(bus.DOTEN), 64'd0);
        step(1, 0, 16'h0C04);
        chk("arst_doten",    64'(bus.DOTEN),    64'd1);
        chk("arst_dot",      bus.DOT,           64'h0C04_0C03_0C02_0C01);
        chk("arst_batchcnt", 64'(bus.BATCHCNT), 64'd1);
        step(0, 0, 16'h0000);
        step(0, 0, 16'h0000);
        chk("arst_final_cnt", 64'(bus.BATCHCNT), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bitonic_loader.md
BITONIC_LOADER -- requirements
Module: bitonic_loader

Interface
REQ-001 SHALL have parameter P_LOG, default 7, log2 of records per batch (N = 1<<P_LOG).
REQ-002 SHALL have parameter DATW, default 64, record width in bits.
REQ-003 SHALL have parameter KEYW, default 32, key width in bits; the key is the low KEYW bits of a record.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port IDATA  input  DATW  incoming record.
REQ-007 SHALL have port IVALID  input  1  IDATA is valid this cycle; no backpressure exists.
REQ-008 SHALL have port IFLUSH  input  1  end of stream; close the current partial batch.
REQ-009 SHALL have port DOT  output  DATW<<P_LOG  assembled batch feeding the sorter DIN.
REQ-010 SHALL have port DOTEN  output  1  one-cycle strobe marking DOT valid, feeding the sorter DINEN.
REQ-011 SHALL have port DOTPAD  output  P_LOG+1  number of pad records in the batch on DOT.
REQ-012 SHALL have port BATCHCNT  output  32  count of batches emitted since reset.

Function
REQ-013 SHALL hold a fill counter CNT (0..N-1) and a staging buffer of N records.
REQ-014 SHALL write an accepted record (IVALID=1) to slot CNT, i.e. buffer bits DATW*(CNT+1)-1 : DATW*CNT, and then increment CNT.
REQ-015 SHALL, on accepting the record when CNT=N-1, copy the full batch to DOT in the next cycle, assert DOTEN for exactly that cycle, drive DOTPAD=0, and wrap CNT to 0.
REQ-016 SHALL accept a new record every cycle, including the cycle in which DOTEN is high; the staging buffer and the DOT register are separate.
REQ-017 SHALL, on IFLUSH=1 with an effective CNT>0, emit the batch in the next cycle with slots CNT..N-1 filled with the pad record (all DATW bits 1), DOTPAD=N-CNT, and CNT cleared to 0.
REQ-018 SHALL treat IFLUSH=1 with an effective CNT=0 as a no-op: no DOTEN and no BATCHCNT change.
REQ-019 SHALL, when IVALID and IFLUSH are high in the same cycle, accept the record first and then apply the flush to the updated count:
  - if that record completes the batch, emit a normal batch (DOTPAD=0) and no additional empty batch;
  - otherwise emit a padded batch that includes the record.
REQ-020 SHALL hold DOT and DOTPAD stable between strobes; DOT is meaningful only while DOTEN=1.
REQ-021 SHALL increment BATCHCNT by 1 in the same cycle DOTEN is asserted, wrapping modulo 2^32.
REQ-022 SHALL NOT overwrite or drop a record, because at most one batch completes per cycle.

Reset
REQ-023 SHALL, while RST=1, force CNT=0, DOTEN=0, DOTPAD=0, BATCHCNT=0 and DOT=0, independent of CLK.
REQ-024 SHALL discard a partially filled batch on reset mid-operation, with no DOTEN after release.
REQ-025 SHALL accept a record in the first rising edge after RST deasserts.

Structure
REQ-026 SHALL take the defaults for P_LOG, DATW and KEYW, and the pad-record constant (all ones), from the shared sorter package used by the BITONIC network and its test tops.
REQ-027 SHALL be a single module with no sub-modules; the slot write is a decoded per-slot enable.
REQ-028 SHALL connect DOT/DOTEN directly to BITONIC DIN/DINEN with no glue logic.

Verification (P_LOG=2, DATW=16, KEYW=8)
REQ-029 Push 0x0004, 0x0003, 0x0002, 0x0001 on consecutive cycles -> one cycle after the 4th: DOTEN=1, DOT=0x0001_0002_0003_0004, DOTPAD=0, BATCHCNT=1.
REQ-030 Push 8 back-to-back records -> two DOTEN pulses exactly 4 cycles apart, no gap in acceptance, BATCHCNT=2.
REQ-031 Push 0x0011, 0x0022, then IFLUSH alone -> DOT=0xFFFF_FFFF_0022_0011, DOTPAD=2.
REQ-032 Push 3 records and assert IFLUSH with the 4th record in the same cycle -> single batch with DOTPAD=0; IFLUSH alone at CNT=0 -> no DOTEN.
REQ-033 Push 2 records, pulse RST asynchronously mid-cycle, then push 4 fresh records -> only one batch, containing only the fresh records, BATCHCNT=1.
REQ-034 End-to-end with BITONIC at P_LOG=2: push 3 random keys plus IFLUSH -> sorted output ascending, with the pad record last.
